port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameters: NREQ, default 4, number of requesters; GRANT_TIMEOUT, default 8, maximum cycles from rdy to pop; XMIT_TIMEOUT, default 40, maximum cycles in XMIT.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fifo_rdy  input  NREQ  requester i FIFO non-empty.
REQ-005 SHALL have port fifo_data  input  32*NREQ  head word of FIFO i, at bits [32i+31:32i].
REQ-006 SHALL have port cfg_enable  input  NREQ  requester i eligible for grant when 1.
REQ-007 SHALL have port pop  input  1  word-accepted pulse from the serializer.
REQ-008 SHALL have port frameo_n  input  1  serializer frame strobe, active-low.
REQ-009 SHALL have port payload  output  32  word presented to the serializer.
REQ-010 SHALL have port rdy  output  1  word available to the serializer, registered.
REQ-011 SHALL have port fifo_pop  output  NREQ  one-hot pop to the granted FIFO.
REQ-012 SHALL have port grant  output  NREQ  one-hot current owner, registered; 0 when idle.
REQ-013 SHALL have port busy  output  1  1 when state is not IDLE.
REQ-014 SHALL have port err_timeout  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, GRANT and XMIT.
REQ-016 IDLE: eligible set = fifo_rdy & cfg_enable; if non-empty, SHALL select by round-robin starting at index ptr, set grant one-hot and rdy=1, and go to GRANT in the same edge.
REQ-017 GRANT: payload SHALL equal the fifo_data slice of the granted index combinationally; when grant=0, payload SHALL be 0.
REQ-018 GRANT: fifo_pop SHALL equal pop AND grant combinationally, giving exactly one FIFO pop per frame.
REQ-019 GRANT: on pop=1, SHALL clear rdy at that edge, clear the frame_seen flag, and go to XMIT.
REQ-020 XMIT: SHALL set frame_seen when frameo_n=0; when frameo_n=1 with frame_seen=1, SHALL go to IDLE, set ptr=(granted index+1) mod NREQ, and clear grant.
REQ-021 Arbitration SHALL start only in IDLE, so no new grant is issued in the cycle the frame completes; minimum gap is one IDLE cycle.
REQ-022 GRANT_TIMEOUT: SHALL count cycles in GRANT; at the count limit without pop, SHALL clear rdy and grant, set err_timeout, go to IDLE, and advance ptr past the stalled index.
REQ-023 XMIT_TIMEOUT: SHALL count cycles in XMIT; at the count limit without frame end, SHALL apply the same recovery as REQ-022.
REQ-024 Deassertion of fifo_rdy or cfg_enable for the owner after grant SHALL NOT revoke the grant; the frame completes.
REQ-025 pop outside GRANT SHALL produce no fifo_pop and SHALL be ignored.
REQ-026 rdy SHALL never be 1 outside GRANT, and fifo_pop SHALL never have more than one bit set.
REQ-027 Timeout counters SHALL be sized for the larger of the two timeouts and SHALL reset to 0 on every state entry.

Reset
REQ-028 On reset_n=0, asynchronously: state=IDLE, rdy=0, grant=0, ptr=0, counters=0, frame_seen=0, err_timeout=0; payload and fifo_pop SHALL then be 0 by REQ-017 and REQ-018.
REQ-029 Reset asserted mid-frame SHALL abort without popping any FIFO; after release, arbitration SHALL restart from requester 0.
REQ-030 err_timeout SHALL clear only on reset.

Structure
REQ-031 State encodings and default timeout constants SHALL reside in the shared router package.
REQ-032 The round-robin priority picker (inputs: eligible vector, ptr; output: one-hot plus index) SHALL be a separate combinational sub-module, rr_pick.

Verification
REQ-033 Scenario, single requester: fifo_rdy=0001, data 0xA5A5_0001, serializer model -> one fifo_pop[0] pulse, serial bits LSB-first match, ptr=1 after frameo_n rises.
REQ-034 Scenario, all requesters ready continuously, cfg_enable=1111 -> grant order 0,1,2,3,0, one frame each, one pop each.
REQ-035 Scenario, fifo_rdy=1010, ptr=0 -> grant 1 then 3; the cfg_enable[3]=0 variant -> requester 1 only, repeatedly.
REQ-036 Scenario, pop held 0 for 8 cycles in GRANT -> rdy falls, err_timeout=1, no fifo_pop, next eligible requester granted.
REQ-037 Scenario, reset_n pulsed low 10 cycles after frame start -> all outputs 0 immediately, err_timeout=0, first grant after release is the lowest-index eligible requester.
REQ-038 Scenario, owner fifo_rdy drops during XMIT -> frame completes; grant holds until frameo_n rises.

Source files
------------

// File: rtl/port_arbiter_pkg.sv
// port_arbiter_pkg
//   Shared router package: FSM state encoding for the port arbiter, default
//   timeout limits and small constant-sizing helpers.
//   No ports.
package port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XMIT  = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_GRANT_TIMEOUT = 8;
    localparam int unsigned DEF_XMIT_TIMEOUT  = 40;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans the eligible vector starting at
//   index ptr and wrapping, returning the first eligible requester.
//   Ports:
//     eligible [NREQ-1:0]  in   requesters that may be granted
//     ptr      [IDXW-1:0]  in   index with highest priority this round
//     onehot   [NREQ-1:0]  out  one-hot of the chosen requester, 0 if none
//     idx      [IDXW-1:0]  out  index of the chosen requester, 0 if none
//     found                out  1 when any requester was chosen
module rr_pick
    import port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = width_for(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    always_comb begin : pick
        int unsigned cand;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && eligible[cand[IDXW-1:0]]) begin
                found                    = 1'b1;
                onehot[cand[IDXW-1:0]]   = 1'b1;
                idx                      = cand[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter
//   Round-robin arbiter handing one FIFO word per frame to a serializer.
//   IDLE picks an owner, GRANT offers its head word until the serializer
//   pops it, XMIT waits for the serializer frame to finish. Both busy states
//   are guarded by timeouts that drop the owner and raise a sticky flag.
//   Ports:
//     clock                    in   rising-edge clock
//     reset_n                  in   asynchronous active-low reset
//     fifo_rdy    [NREQ-1:0]   in   FIFO i non-empty
//     fifo_data   [32*NREQ-1:0] in  head word of FIFO i at [32i+31:32i]
//     cfg_enable  [NREQ-1:0]   in   requester i may be granted
//     pop                      in   serializer accepted the word
//     frameo_n                 in   serializer frame strobe, active-low
//     payload     [31:0]       out  owner's head word, 0 with no owner
//     rdy                      out  word offered to the serializer
//     fifo_pop    [NREQ-1:0]   out  one-hot pop to the owner's FIFO
//     grant       [NREQ-1:0]   out  one-hot owner, 0 when idle
//     busy                     out  arbiter not idle
//     err_timeout              out  sticky timeout flag
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
    parameter int unsigned XMIT_TIMEOUT  = DEF_XMIT_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      fifo_rdy,
    input  logic [32*NREQ-1:0]   fifo_data,
    input  logic [NREQ-1:0]      cfg_enable,
    input  logic                 pop,
    input  logic                 frameo_n,
    output logic [31:0]          payload,
    output logic                 rdy,
    output logic [NREQ-1:0]      fifo_pop,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int unsigned IDXW = width_for(NREQ);
    localparam int unsigned CNTW = width_for(max_u(GRANT_TIMEOUT, XMIT_TIMEOUT));
    // The counter holds cycles already spent in the state, so the last
    // permitted cycle is the one where it reads limit-1.
    localparam logic [CNTW-1:0] GRANT_LAST = CNTW'(GRANT_TIMEOUT - 1);
    localparam logic [CNTW-1:0] XMIT_LAST  = CNTW'(XMIT_TIMEOUT - 1);

    arb_state_t      state, state_nxt;
    logic [IDXW-1:0] owner, owner_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            frame_seen, frame_seen_nxt;
    logic            rdy_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic            err_nxt;
    logic            abandon;
    logic [IDXW-1:0] owner_inc;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_onehot;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;

    assign eligible  = fifo_rdy & cfg_enable;
    assign owner_inc = (owner == IDXW'(NREQ - 1)) ? '0 : owner + 1'b1;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        ptr_nxt        = ptr;
        cnt_nxt        = cnt + 1'b1;
        frame_seen_nxt = frame_seen;
        rdy_nxt        = rdy;
        grant_nxt      = grant;
        err_nxt        = err_timeout;
        abandon        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (pick_found) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = pick_onehot;
                    owner_nxt = pick_idx;
                    rdy_nxt   = 1'b1;
                end
            end
            ST_GRANT: begin
                if (pop) begin
                    state_nxt      = ST_XMIT;
                    rdy_nxt        = 1'b0;
                    frame_seen_nxt = 1'b0;
                    cnt_nxt        = '0;
                end else if (cnt == GRANT_LAST) begin
                    abandon = 1'b1;
                end
            end
            ST_XMIT: begin
                frame_seen_nxt = frame_seen | ~frameo_n;
                // Frame end is the strobe returning high after it was seen low.
                if (frameo_n && frame_seen) begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = owner_inc;
                    cnt_nxt   = '0;
                end else if (cnt == XMIT_LAST) begin
                    abandon = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                rdy_nxt   = 1'b0;
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase

        // Stalled owner: drop it and move priority past it.
        if (abandon) begin
            state_nxt = ST_IDLE;
            rdy_nxt   = 1'b0;
            grant_nxt = '0;
            err_nxt   = 1'b1;
            ptr_nxt   = owner_inc;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            owner       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            frame_seen  <= 1'b0;
            rdy         <= 1'b0;
            grant       <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            frame_seen  <= frame_seen_nxt;
            rdy         <= rdy_nxt;
            grant       <= grant_nxt;
            err_timeout <= err_nxt;
        end
    end

    // AND-OR mux keyed on grant, so no owner means a zero payload.
    always_comb begin
        payload = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                payload = payload | fifo_data[32*i +: 32];
            end
        end
    end

    assign fifo_pop = (state == ST_GRANT && pop) ? grant : '0;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_port_arbiter.sv
module tb_port_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int GT   = 8;
    localparam int XT   = 40;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     fifo_rdy = '0;
    logic [32*NREQ-1:0]  fifo_data = '0;
    logic [NREQ-1:0]     cfg_enable = '1;
    logic                pop = 1'b0;
    logic                frameo_n = 1'b1;
    logic [31:0]         payload;
    logic                rdy;
    logic [NREQ-1:0]     fifo_pop;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                err_timeout;

    always #5 clock = ~clock;

    port_arbiter #(
        .NREQ          (NREQ),
        .GRANT_TIMEOUT (GT),
        .XMIT_TIMEOUT  (XT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fifo_rdy    (fifo_rdy),
        .fifo_data   (fifo_data),
        .cfg_enable  (cfg_enable),
        .pop         (pop),
        .frameo_n    (frameo_n),
        .payload     (payload),
        .rdy         (rdy),
        .fifo_pop    (fifo_pop),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
        logic [IW-1:0] k;
        k = IW'(i);
        return v[k];
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (bit_of(v, i)) return i;
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    // owner < 0 means nobody holds the port; age counts finished cycles of
    // the current phase (waiting for pop, or transmitting).
    int m_owner = -1;
    bit m_wait_pop = 0;
    bit m_seen = 0;
    int m_age = 0;
    int m_ptr = 0;
    bit m_err = 0;
    int m_log[$];

    function automatic int pick_rr(input logic [NREQ-1:0] elig, input int from);
        for (int n = 0; n < NREQ; n++) begin
            int c;
            c = (from + n) % NREQ;
            if (bit_of(elig, c)) return c;
        end
        return -1;
    endfunction

    function automatic void model_abandon();
        m_err      = 1;
        m_ptr      = (m_owner + 1) % NREQ;
        m_owner    = -1;
        m_wait_pop = 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1; m_wait_pop = 0; m_seen = 0; m_age = 0; m_ptr = 0; m_err = 0;
        end else if (m_owner < 0) begin
            int c;
            c = pick_rr(fifo_rdy & cfg_enable, m_ptr);
            if (c >= 0) begin
                m_owner = c; m_wait_pop = 1; m_age = 0;
                m_log.push_back(c);
            end
        end else if (m_wait_pop) begin
            if (pop) begin
                m_wait_pop = 0; m_seen = 0; m_age = 0;
            end else if (m_age + 1 == GT) model_abandon();
            else m_age++;
        end else begin
            if (frameo_n && m_seen) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else begin
                if (m_age + 1 == XT) model_abandon();
                else m_age++;
                if (!frameo_n) m_seen = 1;
            end
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    int dut_log[$];
    int dut_pops[NREQ];
    logic [NREQ-1:0] prev_grant = '0;

    always @(negedge clock) begin
        logic [NREQ-1:0] ge;
        ge = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        chk("grant", 32'(grant), 32'(ge));
        chk("rdy", 32'(rdy), 32'(m_owner >= 0 && m_wait_pop));
        chk("payload", payload, (m_owner >= 0) ? 32'(fifo_data >> (32 * m_owner)) : 32'h0);
        chk("fifo_pop", 32'(fifo_pop), 32'((m_owner >= 0 && m_wait_pop && pop) ? ge : '0));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        chk("fifo_pop_onehot", 32'($countones(fifo_pop) <= 1), 32'h1);
        if (grant != '0 && prev_grant == '0) dut_log.push_back(onehot_idx(grant));
        prev_grant = grant;
        for (int i = 0; i < NREQ; i++) if (bit_of(fifo_pop, i)) dut_pops[i]++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        dut_log.delete();
        m_log.delete();
        for (int i = 0; i < NREQ; i++) dut_pops[i] = 0;
    endtask

    // Expected grant sequence packed one nibble per entry, first entry lowest.
    task automatic chk_log(input string name, input int n, input logic [31:0] seq);
        chk({name, "_len"}, 32'(dut_log.size()), 32'(n));
        chk({name, "_model_len"}, 32'(m_log.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            logic [31:0] e;
            e = (seq >> (4 * k)) & 32'hF;
            if (k < dut_log.size()) chk($sformatf("%s[%0d]", name, k), 32'(dut_log[k]), e);
            if (k < m_log.size()) chk($sformatf("%s_model[%0d]", name, k), 32'(m_log[k]), e);
        end
    endtask

    task automatic chk_pops(input string name, input int p0, input int p1, input int p2, input int p3);
        chk({name, "_pop0"}, 32'(dut_pops[0]), 32'(p0));
        chk({name, "_pop1"}, 32'(dut_pops[1]), 32'(p1));
        chk({name, "_pop2"}, 32'(dut_pops[2]), 32'(p2));
        chk({name, "_pop3"}, 32'(dut_pops[3]), 32'(p3));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; fifo_rdy = '0; cfg_enable = '1; pop = 1'b0; frameo_n = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        clear_obs();
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (rdy) begin ok = 1; break; end
        end
        chk("wait_rdy", 32'(ok), 32'h1);
    endtask

    // Serializer: pop after pop_delay cycles, then drive a frame of flen
    // cycles shifting the captured word out LSB-first. word is the stream
    // reassembled from the shifted bits; held counts frame cycles with a grant.
    task automatic serve(input int pop_delay, input int flen,
                         input logic [NREQ-1:0] rdy_after, input logic [NREQ-1:0] cfg_after,
                         output logic [31:0] word, output int held);
        bit ok;
        logic [31:0] sr;
        word = '0; held = 0;
        wait_rdy(ok);
        if (!ok) return;
        repeat (pop_delay) tick();
        tick();
        pop = 1'b1;
        @(negedge clock);
        sr = payload;
        tick();
        pop = 1'b0; fifo_rdy = rdy_after; cfg_enable = cfg_after;
        frameo_n = 1'b0;
        for (int b = 0; b < flen; b++) begin
            @(negedge clock);
            word = word | (32'(sr[0]) << b);
            sr = sr >> 1;
            if (grant != '0) held++;
            tick();
        end
        frameo_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int held;
        int n;
        bit ok;
        fifo_data = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hA5A5_0001};
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_rdy", 32'(rdy), 32'h0);
        chk("rst_payload", payload, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        apply_reset();

        // single requester, full 32-bit serial frame, then ptr must sit at 1
        fifo_rdy = 4'b0001;
        serve(1, 32, 4'b0000, 4'b1111, w, held);
        chk("s1_serial", w, 32'hA5A5_0001);
        chk_pops("s1", 1, 0, 0, 0);
        fifo_rdy = 4'b0011;
        serve(0, 4, 4'b0000, 4'b1111, w, held);
        chk_log("s1_order", 2, 32'h10);

        // everyone ready continuously
        apply_reset();
        fifo_rdy = 4'b1111;
        repeat (5) serve(0, 3, 4'b1111, 4'b1111, w, held);
        fifo_rdy = '0;
        chk_log("s2_order", 5, 32'h0_3210);
        chk_pops("s2", 2, 1, 1, 1);

        // sparse requesters, then requester 3 disabled
        apply_reset();
        fifo_rdy = 4'b1010;
        repeat (2) serve(0, 3, 4'b1010, 4'b1111, w, held);
        fifo_rdy = '0;
        chk_log("s3_order", 2, 32'h31);
        clear_obs();
        cfg_enable = 4'b0111;
        fifo_rdy = 4'b1010;
        repeat (3) serve(0, 3, 4'b1010, 4'b0111, w, held);
        fifo_rdy = '0;
        chk_log("s3_cfg", 3, 32'h111);
        cfg_enable = '1;

        // grant timeout: no pop for the whole grant window
        apply_reset();
        fifo_rdy = 4'b0011;
        wait_rdy(ok);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!rdy) break;
            n++;
        end
        chk("s4_rdy_cycles", 32'(n), 32'd8);
        chk("s4_err", 32'(err_timeout), 32'h1);
        serve(0, 3, 4'b0000, 4'b1111, w, held);
        chk_log("s4_order", 2, 32'h10);
        chk_pops("s4", 0, 1, 0, 0);

        // transmit timeout: frame strobe never goes low
        apply_reset();
        fifo_rdy = 4'b0001;
        wait_rdy(ok);
        tick(); pop = 1'b1; tick(); pop = 1'b0; fifo_rdy = '0;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (!busy) break;
            n++;
        end
        chk("s5_xmit_cycles", 32'(n), 32'd40);
        chk("s5_err", 32'(err_timeout), 32'h1);
        fifo_rdy = 4'b0011;
        serve(0, 3, 4'b0000, 4'b1111, w, held);
        chk_log("s5_order", 2, 32'h10);

        // owner loses fifo_rdy and cfg_enable mid-frame
        apply_reset();
        fifo_rdy = 4'b0001;
        serve(0, 6, 4'b0000, 4'b0000, w, held);
        chk("s6_held", 32'(held), 32'd6);
        chk_log("s6_order", 1, 32'h0);
        chk_pops("s6", 1, 0, 0, 0);
        cfg_enable = '1;

        // reset mid-frame; err raised first so its clearing is visible
        apply_reset();
        fifo_rdy = 4'b0001;
        wait_rdy(ok);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!rdy) break;
        end
        chk("s7_err_before", 32'(err_timeout), 32'h1);
        fifo_rdy = 4'b0110;
        wait_rdy(ok);
        tick(); pop = 1'b1; tick(); pop = 1'b0; frameo_n = 1'b0;
        repeat (10) tick();
        pop = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("s7_grant", 32'(grant), 32'h0);
        chk("s7_rdy", 32'(rdy), 32'h0);
        chk("s7_payload", payload, 32'h0);
        chk("s7_fifo_pop", 32'(fifo_pop), 32'h0);
        chk("s7_busy", 32'(busy), 32'h0);
        chk("s7_err", 32'(err_timeout), 32'h0);
        clear_obs();
        fifo_rdy = 4'b0101; frameo_n = 1'b1;
        tick(); tick(); tick();
        pop = 1'b0;
        reset_n = 1'b1;
        chk_pops("s7_rst", 0, 0, 0, 0);
        serve(0, 3, 4'b0000, 4'b1111, w, held);
        chk_log("s7_order", 1, 32'h0);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
